// File: rtl/advgen_pkg.sv
// Shared types and widths for the advance-pulse burst generator.
// Imported by advgen_gap and the advgen1 top.
package advgen_pkg;

  localparam int CNT_W = 6;
  localparam int GAP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_t;

  // Narrows the integer GAP parameter to the gap timer width.
  function automatic logic [GAP_W-1:0] gap_cfg(input int gap);
    logic [31:0] g;
    g = 32'(gap);
    return g[GAP_W-1:0];
  endfunction

endpackage

// File: rtl/advgen_gap.sv
// Loadable down-counter that times the idle cycles between advance pulses.
// Holding freezes the count; expired marks the last counted cycle.
module advgen_gap
  import advgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             hold,
  output logic             expired
);

  logic [GAP_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && count != '0) begin
      count <= count - GAP_W'(1);
    end
  end

  assign expired = (count == GAP_W'(1));

endmodule

// File: rtl/advgen1.sv
// Burst generator: clears a downstream counter, then issues N spaced advance strobes.
// Optional readback check of the downstream counter is enabled by defining ADVGEN1_CHECK_EN.
module advgen1
  import advgen_pkg::*;
#(
  parameter int GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n,
  input  logic             i_hold,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_clear,
  output logic             o_advance,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [GAP_W-1:0] GAP_VAL = gap_cfg(GAP);

  state_t           state, state_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             clear_n, adv_n, busy_n, done_n;
  logic             gap_load, gap_expired;

  advgen_gap u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_VAL),
    .hold     (i_hold),
    .expired  (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      o_clear   <= 1'b0;
      o_advance <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      o_clear   <= clear_n;
      o_advance <= adv_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

  // Strobes are decided one edge ahead so every output leaves a flop; in PULSE,
  // o_advance being high means the current cycle is the one that consumes a count.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    clear_n  = 1'b0;
    adv_n    = 1'b0;
    busy_n   = o_busy;
    done_n   = 1'b0;
    gap_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_n = ST_CLEAR;
          rem_n   = i_n;
          clear_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (rem != '0) begin
          state_n = ST_PULSE;
          adv_n   = !i_hold;
        end else begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end
      end
      ST_PULSE: begin
        if (o_advance && rem != '0) begin
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else if (GAP_VAL == '0) begin
            adv_n = !i_hold;
          end else begin
            state_n  = ST_GAP;
            gap_load = 1'b1;
          end
        end else begin
          adv_n = !i_hold;
        end
      end
      ST_GAP: begin
        if (!i_hold && gap_expired) begin
          state_n = ST_PULSE;
          adv_n   = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

`ifdef ADVGEN1_CHECK_EN
  logic [CNT_W-1:0] n_lat;

  // The downstream counter must equal the requested burst length once DONE is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat <= '0;
      o_err <= 1'b0;
    end else if (state == ST_IDLE && i_start) begin
      n_lat <= i_n;
      o_err <= 1'b0;
    end else if (state == ST_DONE && i_count != n_lat) begin
      o_err <= 1'b1;
    end
  end
`else
  logic unused_count;
  assign unused_count = ^i_count;
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_advgen1.sv
// Self-checking bench for advgen1: two instances (GAP=1 and GAP=0) share stimulus and
// are compared cycle by cycle against a schedule derived from the pulse spacing rules.
module tb_advgen1;

  localparam int MAXC = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_start, i_hold;
  logic [5:0] i_n;
  bit   [5:0] cnt [2];
  logic [5:0] rb [2];
  logic       force_en;
  logic [5:0] force_val;
  logic       clr [2], adv [2], busy [2], done [2], err [2];

  int  compared = 0;
  int  mismatched = 0;
  int  gaps [2] = '{1, 0};
  bit  hold_pat [MAXC];
  bit  e_adv [2][MAXC];
  int  done_at [2];
  bit  err_exp [2];
  bit  check_en;

  assign rb[0] = force_en ? force_val : cnt[0];
  assign rb[1] = force_en ? force_val : cnt[1];

  advgen1 #(.GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_n(i_n), .i_hold(i_hold),
    .i_count(rb[0]), .o_clear(clr[0]), .o_advance(adv[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_err(err[0])
  );

  advgen1 #(.GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_n(i_n), .i_hold(i_hold),
    .i_count(rb[1]), .o_clear(clr[1]), .o_advance(adv[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_err(err[1])
  );

  // Downstream 6-bit advance counters read back by each instance
  always @(posedge clk) begin
    if (clr[0]) cnt[0] <= 6'd0;
    else if (adv[0]) cnt[0] <= cnt[0] + 6'd1;
  end

  always @(posedge clk) begin
    if (clr[1]) cnt[1] <= 6'd0;
    else if (adv[1]) cnt[1] <= cnt[1] + 6'd1;
  end

  // Pulse k needs a number of hold-free edges counted from a rule-defined cycle;
  // a pulse appears in the cycle after the edge that satisfies the requirement.
  task automatic plan(input int d, input int n);
    int c, p, need;
    for (int i = 0; i < MAXC; i++) e_adv[d][i] = 1'b0;
    if (n == 0) begin
      done_at[d] = 2;
      return;
    end
    p = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        c = 1; need = 1;
      end else if (gaps[d] == 0) begin
        c = p; need = 1;
      end else begin
        c = p + 1; need = gaps[d];
      end
      while (1) begin
        if (!hold_pat[c]) need--;
        if (need == 0 || c >= MAXC - 4) break;
        c++;
      end
      p = c + 1;
      e_adv[d][p] = 1'b1;
    end
    done_at[d] = p + 1;
  endtask

  task automatic run_burst(input int n, input bit noise, input int rst_at);
    int  last, first_done;
    bit  live, ec, ea, eb, ed;
    logic [5:0] rb_done [2];
    plan(0, n);
    plan(1, n);
    first_done = (done_at[0] < done_at[1]) ? done_at[0] : done_at[1];
    last = ((done_at[0] > done_at[1]) ? done_at[0] : done_at[1]) + 1;
    if (rst_at >= 0) last = rst_at + 15;
    for (int c = 0; c <= last; c++) begin
      i_start = (c == 0) || (noise && c >= 1 && c <= first_done &&
                (rst_at < 0 || c <= rst_at) && $urandom_range(1) == 1);
      i_n     = (c == 0) ? 6'(n) : 6'($urandom);
      i_hold  = hold_pat[c];
      rst     = (c == rst_at);
      @(negedge clk);
      live = (rst_at < 0) || (c <= rst_at);
      for (int d = 0; d < 2; d++) begin
        if (c == done_at[d]) rb_done[d] = rb[d];
        if (!live || c == 1) err_exp[d] = 1'b0;
        if (live && c == done_at[d] + 1 && check_en && rb_done[d] != 6'(n)) err_exp[d] = 1'b1;
        ec = live && (c == 1);
        ea = live && e_adv[d][c];
        eb = live && (c >= 1) && (c <= done_at[d]);
        ed = live && (c == done_at[d]);
        compared += 5;
        if (clr[d] !== ec) begin
          mismatched++;
          $display("[TB] FAIL clear gap%0d n=%0d cyc %0d: got %b want %b", gaps[d], n, c, clr[d], ec);
        end
        if (adv[d] !== ea) begin
          mismatched++;
          $display("[TB] FAIL advance gap%0d n=%0d cyc %0d: got %b want %b", gaps[d], n, c, adv[d], ea);
        end
        if (busy[d] !== eb) begin
          mismatched++;
          $display("[TB] FAIL busy gap%0d n=%0d cyc %0d: got %b want %b", gaps[d], n, c, busy[d], eb);
        end
        if (done[d] !== ed) begin
          mismatched++;
          $display("[TB] FAIL done gap%0d n=%0d cyc %0d: got %b want %b", gaps[d], n, c, done[d], ed);
        end
        if (err[d] !== err_exp[d]) begin
          mismatched++;
          $display("[TB] FAIL err gap%0d n=%0d cyc %0d: got %b want %b", gaps[d], n, c, err[d], err_exp[d]);
        end
      end
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    i_hold  = 1'b0;
    rst     = 1'b0;
    if (rst_at < 0) begin
      for (int d = 0; d < 2; d++) begin
        compared++;
        if (cnt[d] !== 6'(n)) begin
          mismatched++;
          $display("[TB] FAIL count gap%0d: got %0d want %0d", gaps[d], cnt[d], n);
        end
      end
    end
  endtask

  task automatic clear_hold();
    for (int i = 0; i < MAXC; i++) hold_pat[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; i_hold = 1'b0; i_n = 6'd7;
    force_en = 1'b0; force_val = 6'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if ({clr[d], adv[d], busy[d], done[d], err[d]} !== 5'b0) begin
          mismatched++;
          $display("[TB] FAIL reset gap%0d: got %b want 00000", gaps[d],
                   {clr[d], adv[d], busy[d], done[d], err[d]});
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; i_start = 1'b0;
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
  endtask

  task automatic test_basic();
    clear_hold();
    run_burst(5, 1'b0, -1);
  endtask

  task automatic test_zero();
    clear_hold();
    run_burst(0, 1'b1, -1);
  endtask

  task automatic test_max();
    clear_hold();
    run_burst(63, 1'b0, -1);
  endtask

  task automatic test_hold();
    clear_hold();
    for (int i = 3; i <= 5; i++) hold_pat[i] = 1'b1;
    run_burst(4, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    clear_hold();
    for (int k = 0; k < 3; k++) run_burst($urandom_range(8, 1), 1'b1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < MAXC; i++) hold_pat[i] = ($urandom_range(99) < 30);
      run_burst($urandom_range(63), 1'b1, -1);
    end
  endtask

  task automatic test_reset_mid();
    clear_hold();
    run_burst(10, 1'b1, 5);
  endtask

  task automatic test_check();
    clear_hold();
    force_en = 1'b1;
    force_val = 6'd5;
    run_burst(6, 1'b0, -1);
    force_en = 1'b0;
    run_burst(6, 1'b0, -1);
  endtask

  initial begin
`ifdef ADVGEN1_CHECK_EN
    check_en = 1'b1;
`else
    check_en = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
